// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the two-master SRAM arbiter.
package sram_arbiter_pkg;

   typedef logic master_id_t;

   localparam master_id_t M0 = 1'b0;
   localparam master_id_t M1 = 1'b1;

   typedef struct packed {
      logic       valid;
      master_id_t id;
   } rd_track_t;

   localparam int MAX_READ_LATENCY = 4;

endpackage

// File: rtl/sram_arbiter_rr.sv
// Two-way round-robin picker: a lone requester wins, a conflict goes to the
// master that did not win last time.
module sram_arbiter_rr
   import sram_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  master_id_t last_gnt,
   output logic [1:0] gnt,
   output master_id_t gnt_id,
   output logic       any_gnt
);

   always_comb begin
      gnt    = 2'b00;
      gnt[0] = req[0] & (~req[1] | (last_gnt == M1));
      gnt[1] = req[1] & (~req[0] | (last_gnt == M0));
   end

   assign gnt_id  = master_id_t'(gnt[1]);
   assign any_gnt = |req;

endmodule

// File: rtl/sram_arbiter.sv
// Merges two SRAM-style masters onto one SRAM port and steers read data back
// to the issuing master. Optional stall counters: SRAM_ARBITER_PERF_EN.
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int LEN_ADDR     = 32,
   parameter int LEN_DATA     = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  m0_ena,
   input  logic [LEN_DATA/8-1:0] m0_wea,
   input  logic [LEN_ADDR-1:0]   m0_addra,
   input  logic [LEN_DATA-1:0]   m0_dina,
   output logic                  m0_gnt,
   output logic [LEN_DATA-1:0]   m0_douta,
   output logic                  m0_rvalid,
   input  logic                  m1_ena,
   input  logic [LEN_DATA/8-1:0] m1_wea,
   input  logic [LEN_ADDR-1:0]   m1_addra,
   input  logic [LEN_DATA-1:0]   m1_dina,
   output logic                  m1_gnt,
   output logic [LEN_DATA-1:0]   m1_douta,
   output logic                  m1_rvalid,
   output logic                  slave_ena,
   output logic [LEN_DATA/8-1:0] slave_wea,
   output logic [LEN_ADDR-1:0]   slave_addra,
   output logic [LEN_DATA-1:0]   slave_dina,
   input  logic [LEN_DATA-1:0]   slave_douta
`ifdef SRAM_ARBITER_PERF_EN
   ,
   output logic [31:0]           m0_stall_cnt,
   output logic [31:0]           m1_stall_cnt
`endif
);

   // Out-of-range latencies are clamped so the tracking pipe is never empty.
   localparam int DEPTH = (READ_LATENCY < 1) ? 1 :
                          (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY :
                          READ_LATENCY;

   logic [1:0] req;
   logic [1:0] gnt;
   master_id_t gnt_id;
   master_id_t last_gnt;
   logic       any_gnt;
   rd_track_t  push;
   rd_track_t  tail;
   rd_track_t  pipe [DEPTH];

   // Requests are masked in reset so nothing is granted or driven to the SRAM.
   assign req = {m1_ena, m0_ena} & {2{rst_n}};

   sram_arbiter_rr u_rr (
      .req      (req),
      .last_gnt (last_gnt),
      .gnt      (gnt),
      .gnt_id   (gnt_id),
      .any_gnt  (any_gnt)
   );

   assign m0_gnt = gnt[0];
   assign m1_gnt = gnt[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_gnt <= M1;
      end else if (any_gnt) begin
         last_gnt <= gnt_id;
      end
   end

   always_comb begin
      slave_ena   = any_gnt;
      slave_wea   = '0;
      slave_addra = m0_addra;
      slave_dina  = m0_dina;
      if (gnt[1]) begin
         slave_wea   = m1_wea;
         slave_addra = m1_addra;
         slave_dina  = m1_dina;
      end else if (gnt[0]) begin
         slave_wea   = m0_wea;
      end
   end

   always_comb begin
      push       = '0;
      push.valid = any_gnt && (slave_wea == '0);
      push.id    = gnt_id;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= push;
         for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign tail      = pipe[DEPTH-1];
   assign m0_rvalid = tail.valid && (tail.id == M0);
   assign m1_rvalid = tail.valid && (tail.id == M1);
   assign m0_douta  = slave_douta;
   assign m1_douta  = slave_douta;

`ifdef SRAM_ARBITER_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m0_stall_cnt <= '0;
         m1_stall_cnt <= '0;
      end else begin
         if (m0_ena && !m0_gnt && (m0_stall_cnt != '1)) m0_stall_cnt <= m0_stall_cnt + 32'd1;
         if (m1_ena && !m1_gnt && (m1_stall_cnt != '1)) m1_stall_cnt <= m1_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a vector table on a latency-1 instance plus
// hand-written reset, latency-3 and (SRAM_ARBITER_PERF_EN) stall-counter sequences.
module tb_sram_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total_cnt = 0;

   // latency-1 instance signals
   logic        m0_ena, m1_ena;
   logic [3:0]  m0_wea, m1_wea;
   logic [31:0] m0_addra, m1_addra, m0_dina, m1_dina;
   logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [31:0] m0_douta, m1_douta;
   logic        s_ena;
   logic [3:0]  s_wea;
   logic [31:0] s_addra, s_dina, s_douta;
`ifdef SRAM_ARBITER_PERF_EN
   logic [31:0] m0_stall_cnt, m1_stall_cnt;
`endif

   // latency-3 instance signals
   logic        b_m0_ena, b_m1_ena;
   logic [3:0]  b_m0_wea, b_m1_wea;
   logic [31:0] b_m0_addra, b_m1_addra, b_m0_dina, b_m1_dina;
   logic        b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid;
   logic [31:0] b_m0_douta, b_m1_douta;
   logic        b_s_ena;
   logic [3:0]  b_s_wea;
   logic [31:0] b_s_addra, b_s_dina, b_s_douta;
`ifdef SRAM_ARBITER_PERF_EN
   logic [31:0] b_m0_stall_cnt, b_m1_stall_cnt;
`endif

   sram_arbiter #(.LEN_ADDR(32), .LEN_DATA(32), .READ_LATENCY(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_ena(m0_ena), .m0_wea(m0_wea), .m0_addra(m0_addra), .m0_dina(m0_dina),
      .m0_gnt(m0_gnt), .m0_douta(m0_douta), .m0_rvalid(m0_rvalid),
      .m1_ena(m1_ena), .m1_wea(m1_wea), .m1_addra(m1_addra), .m1_dina(m1_dina),
      .m1_gnt(m1_gnt), .m1_douta(m1_douta), .m1_rvalid(m1_rvalid),
      .slave_ena(s_ena), .slave_wea(s_wea), .slave_addra(s_addra),
      .slave_dina(s_dina), .slave_douta(s_douta)
`ifdef SRAM_ARBITER_PERF_EN
      , .m0_stall_cnt(m0_stall_cnt), .m1_stall_cnt(m1_stall_cnt)
`endif
   );

   sram_arbiter #(.LEN_ADDR(32), .LEN_DATA(32), .READ_LATENCY(3)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .m0_ena(b_m0_ena), .m0_wea(b_m0_wea), .m0_addra(b_m0_addra), .m0_dina(b_m0_dina),
      .m0_gnt(b_m0_gnt), .m0_douta(b_m0_douta), .m0_rvalid(b_m0_rvalid),
      .m1_ena(b_m1_ena), .m1_wea(b_m1_wea), .m1_addra(b_m1_addra), .m1_dina(b_m1_dina),
      .m1_gnt(b_m1_gnt), .m1_douta(b_m1_douta), .m1_rvalid(b_m1_rvalid),
      .slave_ena(b_s_ena), .slave_wea(b_s_wea), .slave_addra(b_s_addra),
      .slave_dina(b_s_dina), .slave_douta(b_s_douta)
`ifdef SRAM_ARBITER_PERF_EN
      , .m0_stall_cnt(b_m0_stall_cnt), .m1_stall_cnt(b_m1_stall_cnt)
`endif
   );

   // SRAM models: word at byte address a initially holds 0xC0DE0000 + a.
   logic [31:0] mem1 [0:255];
   logic [31:0] mem3 [0:255];
   logic [31:0] rd1;
   logic [31:0] rd3_0, rd3_1, rd3_2;

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem1[i] = 32'hC0DE_0000 + 32'(i * 4);
         mem3[i] = 32'hC0DE_0000 + 32'(i * 4);
      end
   end

   always @(posedge clk) begin
      if (s_ena) begin
         if (s_wea == 4'b0000) begin
            rd1 <= mem1[s_addra[9:2]];
         end else begin
            for (int b = 0; b < 4; b++)
               if (s_wea[b]) mem1[s_addra[9:2]][8*b +: 8] <= s_dina[8*b +: 8];
         end
      end
   end
   assign s_douta = rd1;

   always @(posedge clk) begin
      if (b_s_ena && (b_s_wea == 4'b0000)) rd3_0 <= mem3[b_s_addra[9:2]];
      rd3_1 <= rd3_0;
      rd3_2 <= rd3_1;
   end
   assign b_s_douta = rd3_2;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic drive(input logic e0, input logic [3:0] w0, input logic [31:0] a0,
                        input logic [31:0] d0, input logic e1, input logic [31:0] a1);
      m0_ena = e0; m0_wea = w0; m0_addra = a0; m0_dina = d0;
      m1_ena = e1; m1_wea = 4'b0000; m1_addra = a1; m1_dina = 32'h1111_1111;
   endtask

   typedef struct {
      logic        m0_ena;
      logic [3:0]  m0_wea;
      logic [31:0] m0_addr;
      logic [31:0] m0_din;
      logic        m1_ena;
      logic [31:0] m1_addr;
      logic [1:0]  gnt;     // {m1, m0}
      logic        s_ena;
      logic [3:0]  s_wea;
      logic [31:0] s_addr;
      logic [31:0] s_din;
      logic [1:0]  rv;      // {m1, m0}
      logic [31:0] rdata;
   } vec_t;

   function automatic vec_t mk(input logic e0, input logic [3:0] w0, input logic [31:0] a0,
                               input logic [31:0] d0, input logic e1, input logic [31:0] a1,
                               input logic [1:0] g, input logic se, input logic [3:0] sw,
                               input logic [31:0] sa, input logic [31:0] sd,
                               input logic [1:0] rv, input logic [31:0] rd);
      vec_t v;
      v.m0_ena = e0; v.m0_wea = w0; v.m0_addr = a0; v.m0_din = d0;
      v.m1_ena = e1; v.m1_addr = a1; v.gnt = g; v.s_ena = se; v.s_wea = sw;
      v.s_addr = sa; v.s_din = sd; v.rv = rv; v.rdata = rd;
      return v;
   endfunction

   localparam int NV = 15;
   localparam logic [31:0] D1 = 32'h1111_1111;
   vec_t vecs [NV];

   logic [1:0]  exp_g [7];
   logic [1:0]  exp_r [7];
   logic [31:0] exp_d [7];

   initial begin
      vecs[0]  = mk(1, 4'h0, 32'h100, 0,            0, 0,     2'b01, 1, 4'h0, 32'h100, 0,            2'b00, 0);
      vecs[1]  = mk(1, 4'h0, 32'h10,  0,            1, 32'h14, 2'b10, 1, 4'h0, 32'h14,  D1,           2'b01, 32'hC0DE_0100);
      vecs[2]  = mk(1, 4'h0, 32'h10,  0,            1, 32'h18, 2'b01, 1, 4'h0, 32'h10,  0,            2'b10, 32'hC0DE_0014);
      vecs[3]  = mk(1, 4'h0, 32'h1C,  0,            1, 32'h18, 2'b10, 1, 4'h0, 32'h18,  D1,           2'b01, 32'hC0DE_0010);
      vecs[4]  = mk(1, 4'h0, 32'h1C,  0,            1, 32'h24, 2'b01, 1, 4'h0, 32'h1C,  0,            2'b10, 32'hC0DE_0018);
      vecs[5]  = mk(1, 4'h3, 32'h20,  32'hDEADBEEF, 0, 0,     2'b01, 1, 4'h3, 32'h20,  32'hDEADBEEF, 2'b01, 32'hC0DE_001C);
      vecs[6]  = mk(0, 4'h0, 0,       0,            1, 32'h20, 2'b10, 1, 4'h0, 32'h20,  D1,           2'b00, 0);
      vecs[7]  = mk(0, 4'h0, 0,       0,            0, 0,     2'b00, 0, 4'h0, 0,       0,            2'b10, 32'hC0DE_BEEF);
      vecs[8]  = mk(1, 4'h0, 32'h40,  0,            1, 32'h44, 2'b01, 1, 4'h0, 32'h40,  0,            2'b00, 0);
      vecs[9]  = mk(0, 4'hF, 32'h60,  32'h5,        0, 32'h44, 2'b00, 0, 4'h0, 32'h60,  32'h5,        2'b01, 32'hC0DE_0040);
      vecs[10] = mk(1, 4'h0, 32'h48,  0,            1, 32'h4C, 2'b10, 1, 4'h0, 32'h4C,  D1,           2'b00, 0);
      vecs[11] = mk(0, 4'h0, 0,       0,            0, 0,     2'b00, 0, 4'h0, 0,       0,            2'b10, 32'hC0DE_004C);
      vecs[12] = mk(0, 4'h0, 0,       0,            1, 32'h50, 2'b10, 1, 4'h0, 32'h50,  D1,           2'b00, 0);
      vecs[13] = mk(0, 4'h0, 0,       0,            1, 32'h54, 2'b10, 1, 4'h0, 32'h54,  D1,           2'b10, 32'hC0DE_0050);
      vecs[14] = mk(0, 4'h0, 0,       0,            0, 0,     2'b00, 0, 4'h0, 0,       0,            2'b10, 32'hC0DE_0054);

      drive(1, 4'hF, 32'h100, 0, 1, 32'h104);
      b_m0_ena = 0; b_m0_wea = 0; b_m0_addra = 0; b_m0_dina = 0;
      b_m1_ena = 0; b_m1_wea = 0; b_m1_addra = 0; b_m1_dina = 0;

      // reset state with both masters requesting
      repeat (2) @(negedge clk);
      #2;
      chk("rst_gnt", {30'd0, m1_gnt, m0_gnt}, 0);
      chk("rst_slave_ena", {31'd0, s_ena}, 0);
      chk("rst_slave_wea", {28'd0, s_wea}, 0);
      chk("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 0);
`ifdef SRAM_ARBITER_PERF_EN
      chk("rst_stall0", m0_stall_cnt, 0);
      chk("rst_stall1", m1_stall_cnt, 0);
`endif
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(vecs[i].m0_ena, vecs[i].m0_wea, vecs[i].m0_addr, vecs[i].m0_din,
               vecs[i].m1_ena, vecs[i].m1_addr);
         #2;
         chk($sformatf("v%0d_gnt", i), {30'd0, m1_gnt, m0_gnt}, {30'd0, vecs[i].gnt});
         chk($sformatf("v%0d_slave_ena", i), {31'd0, s_ena}, {31'd0, vecs[i].s_ena});
         chk($sformatf("v%0d_slave_wea", i), {28'd0, s_wea}, {28'd0, vecs[i].s_wea});
         chk($sformatf("v%0d_slave_addra", i), s_addra, vecs[i].s_addr);
         chk($sformatf("v%0d_slave_dina", i), s_dina, vecs[i].s_din);
         chk($sformatf("v%0d_rvalid", i), {30'd0, m1_rvalid, m0_rvalid}, {30'd0, vecs[i].rv});
         if (vecs[i].rv[0]) chk($sformatf("v%0d_m0_douta", i), m0_douta, vecs[i].rdata);
         if (vecs[i].rv[1]) chk($sformatf("v%0d_m1_douta", i), m1_douta, vecs[i].rdata);
      end

      // reset lands one cycle after an m1 read grant
      @(negedge clk);
      drive(0, 0, 0, 0, 1, 32'h50);
      #2 chk("rr_m1_gnt", {31'd0, m1_gnt}, 1);
      @(negedge clk);
      drive(1, 4'hF, 32'h8, 0, 0, 0);
      rst_n = 1'b0;
      #2;
      chk("rr_m1_rvalid_in_reset", {31'd0, m1_rvalid}, 0);
      chk("rr_gnt_in_reset", {30'd0, m1_gnt, m0_gnt}, 0);
      chk("rr_slave_ena_in_reset", {31'd0, s_ena}, 0);
      chk("rr_slave_wea_in_reset", {28'd0, s_wea}, 0);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #2 chk($sformatf("rr_post_rvalid%0d", k), {30'd0, m1_rvalid, m0_rvalid}, 0);
         @(negedge clk);
      end
      drive(1, 0, 32'h8, 0, 1, 32'hC);
      #2 chk("rr_first_conflict", {30'd0, m1_gnt, m0_gnt}, 2'b01);

      // m0 was last granted; reset must hand the next conflict to m0 again
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      drive(1, 0, 32'h8, 0, 1, 32'hC);
      #2 chk("rr2_first_conflict", {30'd0, m1_gnt, m0_gnt}, 2'b01);

`ifdef SRAM_ARBITER_PERF_EN
      // m1 loses three conflicts, m0 never waits
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (k % 2 == 0) drive(1, 0, 32'h8, 0, 1, 32'hC);
         else            drive(0, 0, 0, 0, 1, 32'hC);
      end
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0);
      #2;
      chk("perf_stall0", m0_stall_cnt, 0);
      chk("perf_stall1", m1_stall_cnt, 3);
`endif

      // latency-3 instance: alternating reads return in order three cycles later
      exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
      exp_g[3] = 2'b00; exp_g[4] = 2'b00; exp_g[5] = 2'b00; exp_g[6] = 2'b00;
      exp_r[0] = 2'b00; exp_r[1] = 2'b00; exp_r[2] = 2'b00;
      exp_r[3] = 2'b01; exp_r[4] = 2'b10; exp_r[5] = 2'b01; exp_r[6] = 2'b00;
      exp_d[3] = 32'hC0DE_0000; exp_d[4] = 32'hC0DE_0004; exp_d[5] = 32'hC0DE_0008;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         b_m0_ena = (c < 3);
         b_m0_addra = (c == 0) ? 32'h0 : 32'h8;
         b_m1_ena = (c < 2);
         b_m1_addra = 32'h4;
         #2;
         chk($sformatf("l3_c%0d_gnt", c), {30'd0, b_m1_gnt, b_m0_gnt}, {30'd0, exp_g[c]});
         chk($sformatf("l3_c%0d_rvalid", c), {30'd0, b_m1_rvalid, b_m0_rvalid}, {30'd0, exp_r[c]});
         if (exp_r[c][0]) chk($sformatf("l3_c%0d_m0_douta", c), b_m0_douta, exp_d[c]);
         if (exp_r[c][1]) chk($sformatf("l3_c%0d_m1_douta", c), b_m1_douta, exp_d[c]);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Merges two SRAM-style masters onto one SRAM port (N:1). This is the converse of the 1:2 SRAM crossbar.
- Intended uses: IF and MEM stages sharing one unified SRAM, or a core and a debug/DMA port sharing one memory.
- Round-robin grant per cycle. Tracks in-flight reads so read data and rvalid reach the master that issued the read, READ_LATENCY cycles later.

Parameters:
- LEN_ADDR, 32, address width.
- LEN_DATA, 32, data width; byte-enable width is LEN_DATA/8.
- READ_LATENCY, 1, SRAM clocks from enable to valid douta; legal range is 1 to 4.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- m0_ena  in  1  master0 request, held until granted.
- m0_wea  in  LEN_DATA/8  master0 byte write enables; all zeros means read.
- m0_addra  in  LEN_ADDR  master0 address.
- m0_dina  in  LEN_DATA  master0 write data.
- m0_gnt  out  1  master0 request accepted this cycle.
- m0_douta  out  LEN_DATA  read data, driven from slave_douta.
- m0_rvalid  out  1  m0_douta valid for master0's read.
- m1_ena, m1_wea, m1_addra, m1_dina, m1_gnt, m1_douta, m1_rvalid: same as master0, for master1.
- slave_ena  out  1  SRAM enable.
- slave_wea  out  LEN_DATA/8  SRAM byte write enables.
- slave_addra  out  LEN_ADDR  SRAM address.
- slave_dina  out  LEN_DATA  SRAM write data.
- slave_douta  in  LEN_DATA  SRAM read data.

Behaviour:
- Reset state:
  - While rst_n=0: gnt, rvalid, slave_ena and slave_wea are all 0.
  - last_gnt resets to 1, so master0 wins the first conflict.
  - The read pipeline clears.
- Grant logic (combinational, same cycle as the request):
  - Exactly one requester: it is granted.
  - Both requesting: the master != last_gnt is granted.
  - At most one gnt is high per cycle.
  - last_gnt updates to the granted id on the clock edge; it holds when there is no grant.
- Slave drive:
  - With a grant, slave_* carry the granted master's signals, and slave_ena=1.
  - With no grant, slave_ena=0 and slave_wea=0; addra and dina carry master0's values (don't-care).
- Handshake:
  - A master keeps ena and its payload stable until gnt.
  - The transfer completes in the cycle gnt=1.
  - A master may present its next request in the following cycle.
  - Back-to-back grants to the same master are allowed when the other master is idle.
- Read tracking:
  - Each grant with wea==0 pushes {valid=1, id} into a shift pipeline of depth READ_LATENCY.
  - A write or no grant pushes valid=0.
  - mI_rvalid is high when the pipeline tail is valid and its id==I.
  - mI_douta always equals slave_douta; rvalid qualifies it.
  - Reads issued in consecutive cycles by alternating masters return in issue order, one per cycle.
  - Writes never produce rvalid.
- Boundary cases:
  - Reset asserted mid-read: the pipeline is flushed and no rvalid follows reset release.
  - ena deasserted without a grant: the request is withdrawn and last_gnt is unchanged.
  - Simultaneous grant and tail-pop: both are handled in the same cycle with full throughput.

Optional Feature:
- Macro: SRAM_ARBITER_PERF_EN.
- When defined:
  - Adds outputs m0_stall_cnt and m1_stall_cnt, 32 bits each.
  - Each counts cycles with mI_ena=1 and mI_gnt=0, saturating at all ones.
  - Both reset to 0.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package sram_arbiter_pkg:
  - typedef master_id_t (1 bit).
  - constants M0=0, M1=1.
  - typedef rd_track_t {valid, id}.
  - constant MAX_READ_LATENCY=4.
- Sub-module sram_arbiter_rr: 2-way round-robin picker.
  - Inputs: req[1:0], last_gnt.
  - Outputs: gnt[1:0], gnt_id, any_gnt.
- Read pipeline and slave muxing stay in the top level.

Test Plan:
- Reset, then m0 read at 0x100 alone -> m0_gnt=1 in the same cycle; slave_addra=0x100, slave_wea=0; m0_rvalid=1 one cycle later with the SRAM data; m1_rvalid stays 0.
- Both request every cycle for 4 cycles -> grants go m0, m1, m0, m1; each waiting master holds its payload until granted.
- m0 write wea=4'b0011, addr 0x20, data 0xDEADBEEF, against an m1 read of 0x20 in the next grant -> slave_wea=0011 on the write cycle; m1_rvalid returns 0x????BEEF from the SRAM model; no m0_rvalid.
- READ_LATENCY=3, alternating reads of 0x0/0x4/0x8 -> rvalid for m0, m1, m0 in three consecutive cycles, starting 3 cycles after the first grant, with correct data.
- Assert rst_n low one cycle after an m1 read grant -> m1_rvalid never rises; after release the first conflict is granted to m0.
- With SRAM_ARBITER_PERF_EN: m1 blocked for 3 cycles while m0 streams and wins -> m1_stall_cnt=3, m0_stall_cnt=0.
